// File: rtl/reg_trace_pkg.sv
// Shared types for the register-write trace monitor.
// Entry layout depends on TRACE_TIMESTAMP_EN.
package reg_trace_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

`ifdef TRACE_TIMESTAMP_EN
  localparam bit TS_STORED = 1'b1;
`else
  localparam bit TS_STORED = 1'b0;
`endif

  // FIFO entry is {addr, data[, timestamp]}.
  function automatic int entry_width(input int aw, input int xlen, input int ts_w);
    return aw + xlen + (TS_STORED ? ts_w : 0);
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO holding captured trace entries; head is visible combinationally.
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
module trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      level_q;
  logic             do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == (PW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + (PW+1)'(1);
        2'b01:   level_q <= level_q - (PW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Storage is not reset, so mask the head while empty.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/reg_trace_monitor.sv
// Captures masked register-file writes during a session into a trace FIFO.
// Optional TRACE_TIMESTAMP_EN stores the session cycle count with each entry.
module reg_trace_monitor #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int DEPTH = 16,
  parameter int LIM_W = 32,
  parameter int TS_W  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       stop,
  input  logic [LIM_W-1:0]           limit,
  input  logic [NREGS-1:0]           watch_mask,
  input  logic                       wb_en,
  input  logic [$clog2(NREGS)-1:0]   wb_addr,
  input  logic [XLEN-1:0]            wb_data,
  output logic                       tr_valid,
  input  logic                       tr_ready,
  output logic [$clog2(NREGS)-1:0]   tr_addr,
  output logic [XLEN-1:0]            tr_data,
  output logic [TS_W-1:0]            tr_ts,
  output logic [$clog2(DEPTH):0]     level,
  output logic [15:0]                ovf_cnt,
  output logic                       busy,
  output logic                       done
);
  import reg_trace_pkg::*;

  localparam int AW = $clog2(NREGS);
  localparam int EW = entry_width(AW, XLEN, TS_W);

  state_e           state_q, state_d;
  logic [LIM_W-1:0] cyc_cnt_q, cyc_cnt_d;
  logic [15:0]      ovf_cnt_q, ovf_cnt_d;
  logic             limit_hit, enter_run, capture;
  logic             fifo_full, fifo_empty;
  logic [EW-1:0]    push_entry, head_entry;

  assign limit_hit = (limit != '0) && (cyc_cnt_q == limit - LIM_W'(1));

  // stop wins over start in every state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start && !stop) state_d = RUN;
      RUN:        if (stop || limit_hit) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  assign enter_run = (state_q != RUN) && (state_d == RUN);
  assign capture   = (state_q == RUN) && wb_en && (wb_addr != '0) && watch_mask[wb_addr];

  always_comb begin
    cyc_cnt_d = cyc_cnt_q;
    ovf_cnt_d = ovf_cnt_q;
    if (enter_run) begin
      cyc_cnt_d = '0;
      ovf_cnt_d = '0;
    end else begin
      if (state_q == RUN) cyc_cnt_d = cyc_cnt_q + LIM_W'(1);
      if (capture && fifo_full && !tr_ready && (ovf_cnt_q != 16'hFFFF))
        ovf_cnt_d = ovf_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cyc_cnt_q <= '0;
      ovf_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cyc_cnt_q <= cyc_cnt_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  trace_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (capture),
    .pop_i   (tr_ready),
    .wdata_i (push_entry),
    .rdata_o (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts;
  assign ts         = TS_W'(cyc_cnt_q);
  assign push_entry = {wb_addr, wb_data, ts};
  assign tr_data    = head_entry[TS_W +: XLEN];
  assign tr_ts      = head_entry[TS_W-1:0];
`else
  assign push_entry = {wb_addr, wb_data};
  assign tr_data    = head_entry[XLEN-1:0];
  assign tr_ts      = '0;
`endif

  assign tr_addr  = head_entry[EW-1 -: AW];
  assign tr_valid = !fifo_empty;
  assign ovf_cnt  = ovf_cnt_q;
  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);

endmodule

// File: tb/tb_reg_trace_monitor.sv
// Randomised bench for reg_trace_monitor against a queue-based session model.
// Honours TRACE_TIMESTAMP_EN for the expected timestamp field.
module tb_reg_trace_monitor;
  localparam int XLEN = 32, NREGS = 32, DEPTH = 16, LIM_W = 32, TS_W = 16;
  localparam int AW = 5, LW = 5;

  logic              clk = 1'b0, reset = 1'b0, start = 1'b0, stop = 1'b0;
  logic [LIM_W-1:0]  limit = '0;
  logic [NREGS-1:0]  watch_mask = '0;
  logic              wb_en = 1'b0;
  logic [AW-1:0]     wb_addr = '0;
  logic [XLEN-1:0]   wb_data = '0;
  logic              tr_ready = 1'b0;
  logic              tr_valid, busy, done;
  logic [AW-1:0]     tr_addr;
  logic [XLEN-1:0]   tr_data;
  logic [TS_W-1:0]   tr_ts;
  logic [LW-1:0]     level;
  logic [15:0]       ovf_cnt;

  reg_trace_monitor #(.XLEN(XLEN), .NREGS(NREGS), .DEPTH(DEPTH), .LIM_W(LIM_W), .TS_W(TS_W)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .limit(limit),
    .watch_mask(watch_mask), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_addr(tr_addr), .tr_data(tr_data),
    .tr_ts(tr_ts), .level(level), .ovf_cnt(ovf_cnt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic [TS_W-1:0] ts;
  } ent_t;

  ent_t            m_q[$];
  int              m_mode;     // 0 idle, 1 running, 2 finished
  longint unsigned m_cyc;
  int unsigned     m_ovf;
  bit              m_known = 1'b0;
  int              n_checks = 0, n_fail = 0;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [TS_W-1:0] exp_ts(input logic [TS_W-1:0] t);
`ifdef TRACE_TIMESTAMP_EN
    return t;
`else
    return '0;
`endif
  endfunction

  task automatic check_outputs();
    chk_eq("tr_valid", tr_valid, m_q.size() != 0);
    chk_eq("level", level, m_q.size());
    chk_eq("ovf_cnt", ovf_cnt, m_ovf);
    chk_eq("busy", busy, m_mode == 1);
    chk_eq("done", done, m_mode == 2);
    if (m_q.size() != 0) begin
      chk_eq("tr_addr", tr_addr, m_q[0].addr);
      chk_eq("tr_data", tr_data, m_q[0].data);
      chk_eq("tr_ts", tr_ts, exp_ts(m_q[0].ts));
    end
  endtask

  // Applies the session rules to the inputs present at the coming edge.
  task automatic model_edge();
    bit   cap, popped;
    ent_t e;
    if (!reset) begin
      m_q.delete();
      m_mode = 0;
      m_cyc  = 0;
      m_ovf  = 0;
      m_known = 1'b1;
      return;
    end
    cap    = (m_mode == 1) && wb_en && (wb_addr != 0) && watch_mask[wb_addr];
    popped = (m_q.size() != 0) && tr_ready;
    if (popped) void'(m_q.pop_front());
    if (cap) begin
      if (m_q.size() < DEPTH) begin
        e.addr = wb_addr;
        e.data = wb_data;
        e.ts   = TS_W'(m_cyc % 65536);
        m_q.push_back(e);
      end else if (m_ovf < 65535) begin
        m_ovf++;
      end
    end
    if (m_mode != 1) begin
      if (start && !stop) begin
        m_mode = 1;
        m_cyc  = 0;
        m_ovf  = 0;
      end
    end else begin
      if (stop || (limit != 0 && m_cyc == longint'(limit) - 1)) m_mode = 2;
      m_cyc = (m_cyc + 1) % (64'd1 << LIM_W);
    end
  endtask

  task automatic step();
    if (m_known) check_outputs();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_busy;
    int phase_ready;
    #1;
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    chk_eq("rst_tr_valid", tr_valid, 0);
    chk_eq("rst_tr_addr", tr_addr, 0);
    chk_eq("rst_tr_data", tr_data, 0);
    chk_eq("rst_tr_ts", tr_ts, 0);
    chk_eq("rst_level", level, 0);
    chk_eq("rst_ovf_cnt", ovf_cnt, 0);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_done", done, 0);

    // Single masked write to x27 at session cycle 3.
    watch_mask = 32'h1 << 27;
    limit = '0;
    start = 1'b1; step(); start = 1'b0;
    step(); step(); step();
    wb_en = 1'b1; wb_addr = 5'd27; wb_data = 32'd5; step(); wb_en = 1'b0;
    chk_eq("x27_valid", tr_valid, 1);
    chk_eq("x27_addr", tr_addr, 27);
    chk_eq("x27_data", tr_data, 5);
    chk_eq("x27_ts", tr_ts, exp_ts(16'd3));
    tr_ready = 1'b1; stop = 1'b1; step(); stop = 1'b0; tr_ready = 1'b0;

    // x0 and an unmasked register are never captured.
    start = 1'b1; step(); start = 1'b0;
    watch_mask = ~(32'h1 << 28);
    wb_en = 1'b1; wb_addr = 5'd0;  wb_data = $urandom; step();
    wb_addr = 5'd28; wb_data = $urandom; step();
    wb_en = 1'b0; step();
    chk_eq("x0_x28_level", level, 0);
    chk_eq("x0_x28_valid", tr_valid, 0);

    // Overflow: 20 writes into 16 entries, then push+pop while full.
    watch_mask = '1;
    for (int i = 0; i < 20; i++) begin
      wb_en = 1'b1; wb_addr = AW'(i % 31 + 1); wb_data = $urandom; step();
    end
    wb_en = 1'b0; step();
    chk_eq("ovf_level", level, 16);
    chk_eq("ovf_count", ovf_cnt, 4);
    wb_en = 1'b1; wb_addr = 5'd9; wb_data = 32'hCAFE; tr_ready = 1'b1; step();
    wb_en = 1'b0; tr_ready = 1'b0;
    chk_eq("full_pushpop_level", level, 16);
    chk_eq("full_pushpop_ovf", ovf_cnt, 4);
    tr_ready = 1'b1; repeat (17) step(); tr_ready = 1'b0;
    stop = 1'b1; step(); stop = 1'b0;

    // Limited session of 10 cycles; writes on cycles 9 and 10.
    limit = 32'd10;
    start = 1'b1; step(); start = 1'b0;
    n_busy = 0;
    for (int c = 0; c < 20; c++) begin
      wb_en = (c == 9) || (c == 10);
      wb_addr = 5'd5;
      wb_data = 32'(100 + c);
      if (busy) n_busy++;
      step();
    end
    wb_en = 1'b0;
    chk_eq("limit_busy_cycles", n_busy, 10);
    chk_eq("limit_done", done, 1);
    chk_eq("limit_level", level, 1);
    chk_eq("limit_data", tr_data, 109);
    chk_eq("limit_ts", tr_ts, exp_ts(16'd9));
    tr_ready = 1'b1; step(); tr_ready = 1'b0;
    limit = '0;

    // Reset during a session with 5 queued entries.
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wb_en = 1'b1; wb_addr = AW'(i + 1); wb_data = $urandom; step();
    end
    wb_en = 1'b0;
    chk_eq("pre_reset_level", level, 5);
    reset = 1'b0; step(); reset = 1'b1;
    chk_eq("midrst_valid", tr_valid, 0);
    chk_eq("midrst_level", level, 0);
    chk_eq("midrst_busy", busy, 0);
    chk_eq("midrst_done", done, 0);

    // Random traffic checked every cycle against the model.
    phase_ready = 2;
    for (int n = 0; n < 3000; n++) begin
      if (n % 500 == 0) phase_ready = $urandom_range(0, 3);
      start = ($urandom % 20) == 0;
      stop  = ($urandom % 40) == 0;
      if (start) limit = (($urandom % 4) == 0) ? '0 : LIM_W'($urandom_range(1, 30));
      if (($urandom % 100) == 0) watch_mask = $urandom;
      wb_en    = $urandom % 2;
      wb_addr  = AW'($urandom % 32);
      wb_data  = $urandom;
      tr_ready = ($urandom % 4) < phase_ready;
      reset    = ($urandom % 600) != 0;
      step();
    end
    reset = 1'b1; start = 1'b0; stop = 1'b0; wb_en = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_trace_monitor.md
REG_TRACE_MONITOR -- requirements
Module: reg_trace_monitor

Interface
REQ-001 SHALL have parameter XLEN, default 32, register data width.
REQ-002 SHALL have parameter NREGS, default 32, register-file size; address width AW = clog2(NREGS).
REQ-003 SHALL have parameter DEPTH, default 16, trace FIFO entries; power of two, >= 2.
REQ-004 SHALL have parameter LIM_W, default 32, cycle-limit counter width.
REQ-005 SHALL have parameter TS_W, default 16, timestamp width.
REQ-006 SHALL have ports, clock and reset first:
  clk  in  1  single clock, rising edge
  reset  in  1  synchronous, active-low reset
  start  in  1  begin capture session (pulse)
  stop  in  1  end capture session (pulse)
  limit  in  LIM_W  session length in cycles; 0 = unlimited
  watch_mask  in  NREGS  bit i set = capture writes to register i
  wb_en  in  1  register-file write enable
  wb_addr  in  AW  write address
  wb_data  in  XLEN  write data
  tr_valid  out  1  trace entry available
  tr_ready  in  1  consumer accepts entry
  tr_addr  out  AW  entry register address
  tr_data  out  XLEN  entry data
  tr_ts  out  TS_W  entry timestamp
  level  out  clog2(DEPTH)+1  FIFO occupancy
  ovf_cnt  out  16  dropped-entry count
  busy  out  1  session running
  done  out  1  session finished

Function
REQ-007 SHALL implement FSM IDLE -> RUN on start; RUN -> DONE on stop, or when cyc_cnt == limit-1 with limit != 0; DONE -> RUN on start.
REQ-008 start in RUN SHALL be ignored; start and stop asserted together SHALL be treated as stop (IDLE stays IDLE, RUN -> DONE, DONE stays DONE).
REQ-009 On entry to RUN, cyc_cnt SHALL clear to 0 and ovf_cnt SHALL clear to 0; FIFO contents SHALL be retained.
REQ-010 cyc_cnt SHALL increment every RUN cycle, wrapping at 2^LIM_W.
REQ-011 Capture condition: state RUN && wb_en && wb_addr != 0 && watch_mask[wb_addr]; writes to x0 SHALL never be captured.
REQ-012 A write is capturable in the same cycle RUN is left (the limit/stop cycle).
REQ-013 Captured entry {wb_addr, wb_data, cyc_cnt[TS_W-1:0]} SHALL appear at the FIFO head no earlier than the next cycle (1-cycle latency when empty).
REQ-014 Pop occurs when tr_valid && tr_ready; tr_valid SHALL be 1 iff level != 0; outputs hold stable while tr_valid && !tr_ready.
REQ-015 Full FIFO with push and no pop: entry dropped, ovf_cnt += 1, saturating at 16'hFFFF.
REQ-016 Full FIFO with simultaneous push and pop: both SHALL succeed and level SHALL stay DEPTH.
REQ-017 Empty FIFO with simultaneous push and pop request: no pop (tr_valid = 0), push accepted.
REQ-018 busy SHALL equal (state == RUN); done SHALL equal (state == DONE).
REQ-019 Pointers SHALL wrap modulo DEPTH; level counts 0..DEPTH inclusive.

Reset
REQ-020 On clk rising edge with reset = 0: state IDLE, FIFO empty, cyc_cnt 0, ovf_cnt 0.
REQ-021 Reset values: tr_valid 0, tr_addr 0, tr_data 0, tr_ts 0, level 0, ovf_cnt 0, busy 0, done 0.
REQ-022 Reset asserted mid-session SHALL discard all FIFO entries and abort the session without asserting done.

Configuration
REQ-023 Macro TRACE_TIMESTAMP_EN defined: FIFO stores the TS_W timestamp and tr_ts carries it.
REQ-024 Macro TRACE_TIMESTAMP_EN undefined: timestamp not stored (FIFO width AW+XLEN), tr_ts tied to 0; all other behaviour identical.

Structure
REQ-025 Package reg_trace_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE) and the entry-width function/constants.
REQ-026 FIFO SHALL be a sub-module trace_fifo (synchronous, parametrised width/depth, full/empty/level).

Verification
REQ-027 watch_mask = 1<<27, limit 0, start, write x27 = 5 at cycle 3 -> one entry {27, 5, ts 3}, tr_valid next cycle.
REQ-028 Write x0 and unmasked x28 while running -> no entries, level 0.
REQ-029 DEPTH 16, tr_ready 0, 20 masked writes -> level 16, ovf_cnt 4; then push+pop in one cycle -> level 16.
REQ-030 limit 10, start -> busy for exactly 10 cycles, then done = 1; write on cycle 9 captured, cycle 10 write not.
REQ-031 Reset low with 5 entries queued during RUN -> next cycle tr_valid 0, level 0, busy 0, done 0.
REQ-032 Build without TRACE_TIMESTAMP_EN -> tr_ts 0 for all entries; addr/data identical to REQ-027 run.
